wall: RTL and testbench

- One moving obstacle for the game's playfield.
- Holds an 11-bit (x, y) position that steps left at a fixed rate.
- When the wall passes the left edge it respawns at the right edge, at a pseudo-random height from an internal LFSR.
- Many instances sit side by side, each made distinct by the START parameter; positions feed the renderer and collision logic in the pixel_clk domain.

---
 rtl/wall_pkg.sv | 33 +++
 rtl/wall_lfsr.sv | 19 +
 rtl/wall.sv | 79 +++++++
 tb/tb_wall.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/wall_pkg.sv
// Shared constants, types and LFSR helpers for the wall obstacle.
package wall_pkg;

  localparam int COORD_W = 11;
  localparam int LFSR_W  = 16;

  // Taps at bits 15, 13, 12 and 10: x^16 + x^14 + x^13 + x^11 + 1.
  localparam logic [LFSR_W-1:0] LFSR_TAPS     = 16'hB400;
  localparam logic [LFSR_W-1:0] LFSR_ZERO_FIX = 16'hACE1;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_Y_MIN    = 40;
  localparam int DEF_Y_SPAN   = 400;

  typedef logic [COORD_W-1:0] coord_t;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

  function automatic logic [LFSR_W-1:0] lfsr_seed(input logic [LFSR_W-1:0] s);
    return (s == '0) ? LFSR_ZERO_FIX : s;
  endfunction

  // Span is at least 256, so a single conditional subtract folds 0..511 into range.
  function automatic logic [9:0] respawn_offset(input logic [LFSR_W-1:0] s,
                                                input logic [9:0]        span);
    logic [9:0] raw;
    raw = {1'b0, s[8:0]};
    return (raw >= span) ? raw - span : raw;
  endfunction

endpackage

// File: rtl/wall_lfsr.sv
// Free-running 16-bit Fibonacci LFSR; load reseeds it, an all-zero seed is replaced.
module wall_lfsr
  import wall_pkg::*;
(
  input  logic              clk,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] value
);

  always_ff @(posedge clk) begin
    if (load) begin
      value <= lfsr_seed(seed);
    end else begin
      value <= lfsr_next(value);
    end
  end

endmodule

// File: rtl/wall.sv
// One moving wall: steps left every MOVE_DIV cycles and respawns at the right edge
// at an LFSR-chosen height. Define WALL_WRAP_PULSE_EN to add the one-cycle wrapped output.
module wall
  import wall_pkg::*;
#(
  parameter int START    = 5,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int Y_MIN    = DEF_Y_MIN,
  parameter int Y_SPAN   = DEF_Y_SPAN,
  parameter int MOVE_DIV = 100000,
  parameter int STEP     = 1
) (
  input  logic   pixel_clk,
  input  logic   reset,
`ifdef WALL_WRAP_PULSE_EN
  output logic   wrapped,
`endif
  output coord_t x,
  output coord_t y
);

  localparam int DIV_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

  localparam coord_t X_RESET   = COORD_W'(START % H_ACTIVE);
  localparam coord_t Y_RESET   = COORD_W'(Y_MIN + (START % Y_SPAN));
  localparam coord_t X_RESPAWN = COORD_W'(H_ACTIVE - 1);
  localparam coord_t STEP_C    = COORD_W'(STEP);
  localparam coord_t Y_MIN_C   = COORD_W'(Y_MIN);
  localparam logic [9:0] SPAN_C = 10'(Y_SPAN);

  localparam logic [31:0]       START_BITS = 32'(START);
  localparam logic [LFSR_W-1:0] SEED       = START_BITS[LFSR_W-1:0];
  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(MOVE_DIV - 1);

  logic [DIV_W-1:0]  cnt;
  logic [LFSR_W-1:0] lfsr;
  logic              tick;
  logic              respawn;
  coord_t            y_spawn;

  wall_lfsr u_lfsr (
    .clk   (pixel_clk),
    .load  (reset),
    .seed  (SEED),
    .value (lfsr)
  );

  assign tick    = (cnt == DIV_LAST);
  assign respawn = tick && (x < STEP_C);
  // Uses the pre-shift LFSR value seen in the tick cycle.
  assign y_spawn = Y_MIN_C + COORD_W'(respawn_offset(lfsr, SPAN_C));

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      cnt <= '0;
      x   <= X_RESET;
      y   <= Y_RESET;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (respawn) begin
        x <= X_RESPAWN;
        y <= y_spawn;
      end else if (tick) begin
        x <= x - STEP_C;
      end
    end
  end

`ifdef WALL_WRAP_PULSE_EN
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      wrapped <= 1'b0;
    end else begin
      wrapped <= respawn;
    end
  end
`endif

endmodule

// File: tb/tb_wall.sv
// Self-checking bench for wall: behavioural model per instance plus directed literal pins.
module tb_wall;

  localparam int N = 12;

  function automatic int start_of(input int i);
    if (i == 0) return 0;
    if (i == 11) return 700;
    return 50 * (i - 1) + (i - 1) * (i - 1) + 5;
  endfunction

  function automatic int div_of(input int i);
    return (i == 11) ? 3 : 4;
  endfunction

  function automatic int step_of(input int i);
    return (i == 11) ? 7 : 1;
  endfunction

  logic        pixel_clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] x_arr [N];
  logic [10:0] y_arr [N];
`ifdef WALL_WRAP_PULSE_EN
  logic        wr_arr [N];
`endif

  always #5 pixel_clk = ~pixel_clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    wall #(
      .START    (start_of(g)),
      .MOVE_DIV (div_of(g)),
      .STEP     (step_of(g))
    ) u_dut (
      .pixel_clk (pixel_clk),
      .reset     (reset),
`ifdef WALL_WRAP_PULSE_EN
      .wrapped   (wr_arr[g]),
`endif
      .x         (x_arr[g]),
      .y         (y_arr[g])
    );
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Model state: position, LFSR, edges since reset release, wrap pulse.
  typedef struct {
    int x;
    int y;
    int lfsr;
    int n;
    bit wr;
    bit valid;
  } mst_t;

  mst_t m [N];

  function automatic int lfsr_step(input int v);
    return ((v << 1) & 32'hFFFF) | (((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1);
  endfunction

  function automatic mst_t model_next(input mst_t s, input bit rst, input int i);
    mst_t o = s;
    int   st = start_of(i);
    int   r;
    if (rst) begin
      o.x = st % 640;
      o.y = 40 + st % 400;
      o.lfsr = st & 32'hFFFF;
      if (o.lfsr == 0) o.lfsr = 32'hACE1;
      o.n = 0;
      o.wr = 1'b0;
      o.valid = 1'b1;
    end else if (s.valid) begin
      o.n = s.n + 1;
      o.wr = 1'b0;
      if (o.n % div_of(i) == 0) begin
        if (s.x >= step_of(i)) begin
          o.x = s.x - step_of(i);
        end else begin
          o.x = 639;
          r = s.lfsr & 511;
          if (r >= 400) r = r - 400;
          o.y = 40 + r;
          o.wr = 1'b1;
        end
      end
      o.lfsr = lfsr_step(s.lfsr);
    end
    return o;
  endfunction

  always @(posedge pixel_clk) begin
    for (int i = 0; i < N; i++) m[i] <= model_next(m[i], reset, i);
  end

  bit          seen [N];
  logic [10:0] first_y [N];

  always @(negedge pixel_clk) begin
    for (int i = 0; i < N; i++) begin
      if (m[i].valid) begin
        chk($sformatf("model_x[%0d]", i), 32'(x_arr[i]), m[i].x);
        chk($sformatf("model_y[%0d]", i), 32'(y_arr[i]), m[i].y);
`ifdef WALL_WRAP_PULSE_EN
        chk($sformatf("model_wrapped[%0d]", i), 32'(wr_arr[i]), 32'(m[i].wr));
`endif
        if (reset) seen[i] = 1'b0;
        else if (m[i].wr && !seen[i]) begin
          seen[i] = 1'b1;
          first_y[i] = y_arr[i];
        end
      end
    end
  end

  task automatic step();
    @(posedge pixel_clk);
    #1;
  endtask

  int found;
  int distinct;
  bit dup;

  initial begin
    // Reset held for three edges.
    for (int e = 0; e < 3; e++) begin
      step();
      chk("reset_x5", 32'(x_arr[1]), 5);
      chk("reset_y5", 32'(y_arr[1]), 45);
      chk("reset_x0", 32'(x_arr[0]), 0);
      chk("reset_y0", 32'(y_arr[0]), 40);
      chk("reset_x700", 32'(x_arr[11]), 60);
      chk("reset_y700", 32'(y_arr[11]), 340);
    end
    for (int k = 1; k <= 10; k++)
      chk($sformatf("reset_x_inst%0d", k), 32'(x_arr[k]), 50 * (k - 1) + (k - 1) * (k - 1) + 5);
    dup = 1'b0;
    for (int a = 1; a <= 10; a++)
      for (int b = a + 1; b <= 10; b++)
        if (x_arr[a] === x_arr[b]) dup = 1'b1;
    chk("reset_x_distinct", 32'(dup), 0);

    // Motion and wrap from START=5; zero-seed instance respawns on the first tick.
    reset = 1'b0;
    for (int e = 1; e <= 25; e++) begin
      step();
      if (e <= 23) begin
        chk("motion_x", 32'(x_arr[1]), 5 - e / 4);
        chk("motion_y", 32'(y_arr[1]), 45);
      end
      if (e == 4) begin
        chk("zero_seed_x", 32'(x_arr[0]), 639);
        chk("zero_seed_y", 32'(y_arr[0]), 311);
      end
`ifdef WALL_WRAP_PULSE_EN
      if (e == 4)  chk("zero_seed_wrapped_hi", 32'(wr_arr[0]), 1);
      if (e == 5)  chk("zero_seed_wrapped_lo", 32'(wr_arr[0]), 0);
      if (e == 24) chk("wrap_pulse_hi", 32'(wr_arr[1]), 1);
      if (e == 25) chk("wrap_pulse_lo", 32'(wr_arr[1]), 0);
`endif
      if (e == 24) begin
        chk("wrap_x", 32'(x_arr[1]), 639);
        chk("wrap_y_range", 32'(y_arr[1] >= 40 && y_arr[1] <= 439), 1);
      end
    end

    // Mid-run reset while x=2 and the divider is half way.
    reset = 1'b1;
    step();
    reset = 1'b0;
    found = 0;
    for (int e = 1; e <= 100; e++) begin
      step();
      if (x_arr[1] == 11'd2) begin
        found = e;
        break;
      end
    end
    chk("reach_x2_edges", found, 12);
    step();
    step();
    reset = 1'b1;
    step();
    chk("midreset_x", 32'(x_arr[1]), 5);
    chk("midreset_y", 32'(y_arr[1]), 45);
    reset = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      step();
      chk("midreset_restart_x", 32'(x_arr[1]), (e < 4) ? 5 : 4);
    end

    // Long clean run so every instance respawns at least once.
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (2300) step();
    distinct = 0;
    for (int a = 1; a <= 10; a++) begin
      chk($sformatf("respawned_inst%0d", a), 32'(seen[a]), 1);
      dup = 1'b0;
      for (int b = 1; b < a; b++)
        if (first_y[a] === first_y[b]) dup = 1'b1;
      if (!dup) distinct++;
    end
    chk("respawn_y_distinct_enough", 32'(distinct >= 5), 1);

    // Random reset bursts against the model.
    repeat (4000) begin
      step();
      if ($urandom_range(0, 199) == 0) reset = 1'b1;
      else reset = reset && ($urandom_range(0, 1) == 1);
    end
    reset = 1'b0;
    repeat (50) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
